// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Brief    : Shared ALU opcodes, MIPS opcode/funct fields and controller
//             FSM state type for the execute controller slice.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  // ALU operation codes seen on alu_opr
  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] ADD  = 3'b001;
  localparam logic [2:0] SUB  = 3'b010;
  localparam logic [2:0] AND  = 3'b011;
  localparam logic [2:0] OR   = 3'b100;
  localparam logic [2:0] SLT  = 3'b101;

  // Primary opcode field instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // R-type funct field instr[5:0]
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_exec_ctrl_if
//  Brief    : Instruction handshake and retirement bus between fetch
//             (master) and the execute controller (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface mips_exec_ctrl_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        done;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        illegal;

  modport master (
    output in_valid, in_instr,
    input  in_ready, done, br_taken, br_offset, illegal
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, done, br_taken, br_offset, illegal
  );
endinterface
`default_nettype wire

// File: rtl/mips_alu.sv
`default_nettype none
// ============================================================================
//  Module   : mips_alu
//  Brief    : Combinational 32-bit ALU (add/sub/and/or/unsigned slt) with
//             zero flag. Wrap-around arithmetic, no overflow reporting.
//  Revision : 1.0  initial release
// ============================================================================
module mips_alu
  import mips_pkg::*;
(
  input  logic [2:0]  opr,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res,
  output logic        zf
);

  // Select the operation result; unknown opcodes yield zero
  always_comb begin
    res = 32'h0;
    case (opr)
      ADD:     res = a + b;
      SUB:     res = a - b;
      AND:     res = a & b;
      OR:      res = a | b;
      SLT:     res = {31'h0, (a < b)};
      default: res = 32'h0;
    endcase
    zf = (res == 32'h0);
  end

endmodule
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : mips_regfile
//  Brief    : 32x32 register file, two combinational read ports plus a
//             debug read port, one synchronous write port. $0 reads zero
//             and ignores writes.
//  Revision : 1.0  initial release
// ============================================================================
module mips_regfile #(
  parameter logic [31:0] REG_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // Apply the single write, never touching $0
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage update with async reset of every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= REG_RESET;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: $0 is hardwired to zero regardless of REG_RESET
  always_comb begin
    rdata_a  = (raddr_a  == 5'd0) ? 32'h0 : regs_q[raddr_a];
    rdata_b  = (raddr_b  == 5'd0) ? 32'h0 : regs_q[raddr_b];
    dbg_data = (dbg_addr == 5'd0) ? 32'h0 : regs_q[dbg_addr];
  end

endmodule
`default_nettype wire

// File: rtl/mips_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_exec_ctrl
//  Brief    : Multi-cycle execute controller: accept, decode, drive the
//             external ALU, write back and report branch outcome.
//  Revision : 1.0  initial release
// ============================================================================
module mips_exec_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] REG_RESET = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  mips_exec_ctrl_if.slave   bus,
  output logic [2:0]        alu_opr,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_res,
  input  logic              alu_zf,
  input  logic [4:0]        dbg_addr,
  output logic [31:0]       dbg_data
);

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] res_q, res_d;
  logic [2:0]  opr_q, opr_d;
  logic [4:0]  dest_q, dest_d;
  logic        wen_q, wen_d;
  logic        beq_q, beq_d;
  logic        illegal_q, illegal_d;
  logic        zf_q, zf_d;

  logic [31:0] rs_data, rt_data;
  logic        rf_we;

  logic [31:0] imm_sext;
  logic [2:0]  dec_opr;
  logic [31:0] dec_b;
  logic [4:0]  dec_dest;
  logic        dec_wen, dec_beq, dec_illegal;
  logic        unused_shamt;

  // shamt is not used by any supported instruction
  assign unused_shamt = ^instr_q[10:6];
  assign imm_sext     = {{16{instr_q[15]}}, instr_q[15:0]};

  mips_regfile #(.REG_RESET(REG_RESET)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr_a  (instr_q[25:21]),
    .rdata_a  (rs_data),
    .raddr_b  (instr_q[20:16]),
    .rdata_b  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .waddr    (dest_q),
    .wdata    (res_q)
  );

  // Decode the latched instruction word into ALU op, operand B and dest
  always_comb begin
    dec_opr     = NONE;
    dec_b       = rt_data;
    dec_dest    = instr_q[15:11];
    dec_wen     = 1'b0;
    dec_beq     = 1'b0;
    dec_illegal = 1'b0;
    case (instr_q[31:26])
      OP_RTYPE: begin
        dec_wen = 1'b1;
        case (instr_q[5:0])
          F_ADD:   dec_opr = ADD;
          F_SUB:   dec_opr = SUB;
          F_AND:   dec_opr = AND;
          F_OR:    dec_opr = OR;
          F_SLT:   dec_opr = SLT;
          default: begin
            dec_illegal = 1'b1;
            dec_wen     = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_opr  = ADD;
        dec_b    = imm_sext;
        dec_dest = instr_q[20:16];
        dec_wen  = 1'b1;
      end
      OP_BEQ: begin
        dec_opr = SUB;
        dec_beq = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // FSM next state, datapath capture and all controller outputs
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    res_d         = res_q;
    opr_d         = opr_q;
    dest_d        = dest_q;
    wen_d         = wen_q;
    beq_d         = beq_q;
    illegal_d     = illegal_q;
    zf_d          = zf_q;
    bus.in_ready  = 1'b0;
    bus.done      = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_offset = 32'h0;
    bus.illegal   = 1'b0;
    alu_opr       = NONE;
    alu_a         = 32'h0;
    alu_b         = 32'h0;
    rf_we         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          instr_d = bus.in_instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        opa_d     = rs_data;
        opb_d     = dec_b;
        opr_d     = dec_opr;
        dest_d    = dec_dest;
        wen_d     = dec_wen;
        beq_d     = dec_beq;
        illegal_d = dec_illegal;
        // Illegal words skip the ALU entirely and retire one cycle early
        state_d   = dec_illegal ? ST_WB : ST_EXEC;
      end
      ST_EXEC: begin
        alu_opr = opr_q;
        alu_a   = opa_q;
        alu_b   = opb_q;
        res_d   = alu_res;
        zf_d    = alu_zf;
        state_d = ST_WB;
      end
      ST_WB: begin
        bus.done      = 1'b1;
        bus.br_taken  = beq_q & zf_q;
        bus.br_offset = {imm_sext[29:0], 2'b00};
        bus.illegal   = illegal_q;
        rf_we         = wen_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= 32'h0;
      opa_q     <= 32'h0;
      opb_q     <= 32'h0;
      res_q     <= 32'h0;
      opr_q     <= NONE;
      dest_q    <= 5'd0;
      wen_q     <= 1'b0;
      beq_q     <= 1'b0;
      illegal_q <= 1'b0;
      zf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      opr_q     <= opr_d;
      dest_q    <= dest_d;
      wen_q     <= wen_d;
      beq_q     <= beq_d;
      illegal_q <= illegal_d;
      zf_q      <= zf_d;
    end
  end

endmodule
`default_nettype wire
